// File: rtl/dmem_access_ctrl.sv
// dmem_access_ctrl: load/store access controller for a 128x32 word-addressed
// data memory. Byte-addressed byte/half/word requests arrive over a
// ready/valid handshake. Sub-word stores use read-modify-write, and sub-word
// loads are lane-selected and then sign- or zero-extended. Misaligned or
// illegal-size requests complete with an error and never touch memory.
module dmem_access_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [8:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_done,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic [6:0]  mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  state_t      state_q, state_d;
  logic        store_q, store_d;
  logic [1:0]  size_q, size_d;
  logic        uns_q, uns_d;
  logic [1:0]  lane_q, lane_d;
  logic [6:0]  idx_q, idx_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] buf_q, buf_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;
  logic        req_err_s;

  // Pick the addressed lane out of a little-endian word and extend it to 32 bits.
  function automatic logic [31:0] load_fmt(input logic [31:0] word,
                                           input logic [1:0]  size,
                                           input logic [1:0]  lane,
                                           input logic        uns);
    logic [31:0] sh;
    sh = word >> {lane, 3'b000};
    case (size)
      SZ_BYTE: load_fmt = uns ? {24'h000000, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
      SZ_HALF: load_fmt = uns ? {16'h0000, sh[15:0]}   : {{16{sh[15]}}, sh[15:0]};
      default: load_fmt = word;
    endcase
  endfunction

  // Overlay the right-justified store data onto the addressed lane of the old word.
  function automatic logic [31:0] store_merge(input logic [31:0] word,
                                              input logic [31:0] wdata,
                                              input logic [1:0]  size,
                                              input logic [1:0]  lane);
    logic [31:0] mask;
    logic [31:0] smask;
    mask  = (size == SZ_BYTE) ? 32'h0000_00FF : 32'h0000_FFFF;
    smask = mask << {lane, 3'b000};
    store_merge = (word & ~smask) | ((wdata & mask) << {lane, 3'b000});
  endfunction

  // Misaligned or illegal-size request check on the incoming request.
  always_comb begin
    case (req_size)
      SZ_BYTE: req_err_s = 1'b0;
      SZ_HALF: req_err_s = req_addr[0];
      SZ_WORD: req_err_s = (req_addr[1:0] != 2'b00);
      default: req_err_s = 1'b1;
    endcase
  end

  // Next-state and datapath latch logic.
  always_comb begin
    state_d = state_q;
    store_d = store_q;
    size_d  = size_q;
    uns_d   = uns_q;
    lane_d  = lane_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    buf_d   = buf_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          store_d = req_store;
          size_d  = req_size;
          uns_d   = req_unsigned;
          lane_d  = req_addr[1:0];
          idx_d   = req_addr[8:2];
          wdata_d = req_wdata;
          err_d   = req_err_s;
          if (req_err_s) begin
            state_d = S_DONE;
          end else if (req_store && (req_size == SZ_WORD)) begin
            state_d = S_WRITE;
          end else begin
            state_d = S_READ;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_READ: begin
        buf_d = mem_rdata;
        if (store_q) begin
          state_d = S_WRITE;
        end else begin
          // Load result lands in resp_rdata on the edge that enters DONE.
          rdata_d = load_fmt(mem_rdata, size_q, lane_q, uns_q);
          state_d = S_DONE;
        end
      end
      S_WRITE: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and latch registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      store_q <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      lane_q  <= 2'b00;
      idx_q   <= 7'd0;
      wdata_q <= 32'd0;
      buf_q   <= 32'd0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      store_q <= store_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      lane_q  <= lane_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      buf_q   <= buf_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // Outputs decoded from registered state; the write enable is gated by reset
  // so that a WRITE cycle coinciding with reset never reaches memory.
  always_comb begin
    req_ready  = (state_q == S_IDLE);
    resp_done  = (state_q == S_DONE);
    resp_err   = err_q;
    resp_rdata = rdata_q;
    mem_addr   = idx_q;
    mem_we     = (state_q == S_WRITE) && rst;
    if (state_q == S_WRITE) begin
      if (size_q == SZ_WORD) begin
        mem_wdata = wdata_q;
      end else begin
        mem_wdata = store_merge(buf_q, wdata_q, size_q, lane_q);
      end
    end else begin
      mem_wdata = 32'd0;
    end
  end

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl with a behavioural 128x32 memory.
module tb_dmem_access_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_store;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [8:0]  req_addr;
  logic [31:0] req_wdata;
  logic        resp_done;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic [6:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;

  logic [31:0] mem [128];
  logic        bd_we;
  logic [6:0]  bd_addr;
  logic [31:0] bd_data;

  int checks;
  int errors;
  int we_cnt;
  int done_cnt;
  logic [6:0]  we_addr;
  logic [31:0] we_data;

  dmem_access_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_done(resp_done), .resp_err(resp_err),
    .resp_rdata(resp_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];

  // Memory: controller writes plus bench preload port.
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    else if (bd_we) mem[bd_addr] <= bd_data;
  end

  // Observe write pulses and completions mid-cycle.
  always @(negedge clk) begin
    if (mem_we) begin
      we_cnt  = we_cnt + 1;
      we_addr = mem_addr;
      we_data = mem_wdata;
    end
    if (resp_done) done_cnt = done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    if (obs !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [6:0] a, input logic [31:0] d);
    @(negedge clk);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    @(posedge clk);
    #1;
    bd_we = 1'b0;
  endtask

  // Issue one request, return cycles from acceptance to resp_done.
  task automatic do_req(input logic st, input logic [1:0] sz, input logic un,
                        input logic [8:0] a, input logic [31:0] wd,
                        output int lat, output logic err, output logic [31:0] rd);
    @(negedge clk);
    req_store = st; req_size = sz; req_unsigned = un; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_done && lat < 8) begin
      @(posedge clk);
      #1;
      lat = lat + 1;
    end
    err = resp_err;
    rd  = resp_rdata;
    @(posedge clk);
    #1;
    chk("done_pulse_width", {31'd0, resp_done}, 32'd0);
  endtask

  int          lat;
  logic        err;
  logic [31:0] rd;
  int          w0;
  int          d0;

  initial begin
    checks = 0; errors = 0; we_cnt = 0; done_cnt = 0;
    we_addr = 7'd0; we_data = 32'd0;
    bd_we = 1'b0; bd_addr = 7'd0; bd_data = 32'd0;
    for (int i = 0; i < 128; i++) mem[i] = 32'd0;
    rst = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 9'd0; req_wdata = 32'd0;

    // Reset state
    @(posedge clk); @(posedge clk); #1;
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_we", {31'd0, mem_we}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_done", {31'd0, resp_done}, 32'd0);
    chk("rst_err", {31'd0, resp_err}, 32'd0);
    chk("rst_maddr", {25'd0, mem_addr}, 32'd0);
    chk("rst_mwdata", mem_wdata, 32'd0);
    rst = 1'b1;

    // Word store then word load
    w0 = we_cnt;
    do_req(1'b1, 2'b10, 1'b0, 9'h010, 32'hDEADBEEF, lat, err, rd);
    chk("wst_lat", 32'(lat), 32'd2);
    chk("wst_err", {31'd0, err}, 32'd0);
    chk("wst_we_cnt", 32'(we_cnt - w0), 32'd1);
    chk("wst_we_addr", {25'd0, we_addr}, 32'd4);
    chk("wst_mem", mem[4], 32'hDEADBEEF);
    w0 = we_cnt;
    do_req(1'b0, 2'b10, 1'b0, 9'h010, 32'd0, lat, err, rd);
    chk("wld_lat", 32'(lat), 32'd2);
    chk("wld_rdata", rd, 32'hDEADBEEF);
    chk("wld_no_we", 32'(we_cnt - w0), 32'd0);

    // Byte store read-modify-write
    preload(7'd4, 32'h11223344);
    w0 = we_cnt;
    do_req(1'b1, 2'b00, 1'b0, 9'h012, 32'hFFFFFFA5, lat, err, rd);
    chk("bst_lat", 32'(lat), 32'd3);
    chk("bst_we_cnt", 32'(we_cnt - w0), 32'd1);
    chk("bst_we_data", we_data, 32'h11A53344);
    chk("bst_mem", mem[4], 32'h11A53344);
    chk("bst_rdata_kept", rd, 32'hDEADBEEF);

    // Sub-word loads
    preload(7'd4, 32'h80F07F01);
    do_req(1'b0, 2'b00, 1'b0, 9'h013, 32'd0, lat, err, rd);
    chk("lb_s3", rd, 32'hFFFFFF80);
    chk("lb_lat", 32'(lat), 32'd2);
    do_req(1'b0, 2'b00, 1'b1, 9'h013, 32'd0, lat, err, rd);
    chk("lbu_3", rd, 32'h00000080);
    do_req(1'b0, 2'b01, 1'b0, 9'h012, 32'd0, lat, err, rd);
    chk("lh_s2", rd, 32'hFFFF80F0);
    do_req(1'b0, 2'b01, 1'b1, 9'h010, 32'd0, lat, err, rd);
    chk("lhu_0", rd, 32'h00007F01);
    do_req(1'b0, 2'b00, 1'b0, 9'h010, 32'd0, lat, err, rd);
    chk("lb_s0", rd, 32'h00000001);

    // Half store into upper lane of word 5
    preload(7'd5, 32'h12345678);
    do_req(1'b1, 2'b01, 1'b0, 9'h016, 32'h0000BEEF, lat, err, rd);
    chk("hst_lat", 32'(lat), 32'd3);
    chk("hst_mem", mem[5], 32'hBEEF5678);
    chk("hst_rdata_kept", rd, 32'h00000001);

    // Error requests
    w0 = we_cnt;
    do_req(1'b0, 2'b01, 1'b0, 9'h013, 32'd0, lat, err, rd);
    chk("mis_half_lat", 32'(lat), 32'd1);
    chk("mis_half_err", {31'd0, err}, 32'd1);
    do_req(1'b1, 2'b10, 1'b0, 9'h012, 32'hCAFEF00D, lat, err, rd);
    chk("mis_word_lat", 32'(lat), 32'd1);
    chk("mis_word_err", {31'd0, err}, 32'd1);
    do_req(1'b1, 2'b11, 1'b0, 9'h010, 32'hCAFEF00D, lat, err, rd);
    chk("ill_size_lat", 32'(lat), 32'd1);
    chk("ill_size_err", {31'd0, err}, 32'd1);
    chk("err_no_we", 32'(we_cnt - w0), 32'd0);
    chk("err_mem4", mem[4], 32'h80F07F01);
    chk("err_rdata_kept", rd, 32'h00000001);
    do_req(1'b0, 2'b10, 1'b0, 9'h014, 32'd0, lat, err, rd);
    chk("ok_after_err", {31'd0, err}, 32'd0);
    chk("ok_after_err_rd", rd, 32'hBEEF5678);

    // Reset during the WRITE cycle of a byte store
    w0 = we_cnt; d0 = done_cnt;
    @(negedge clk);
    req_store = 1'b1; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = 9'h010; req_wdata = 32'h00000055; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    chk("rstw_we", {31'd0, mem_we}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rstw_ready", {31'd0, req_ready}, 32'd1);
    chk("rstw_no_done", 32'(done_cnt - d0), 32'd0);
    chk("rstw_no_we", 32'(we_cnt - w0), 32'd0);
    chk("rstw_mem", mem[4], 32'h80F07F01);
    chk("rstw_rdata", resp_rdata, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_access_ctrl.md
# dmem_access_ctrl

Load/store access controller sitting between the CPU datapath and the 128×32 word-addressed data memory. It accepts byte-addressed load and store requests of byte, halfword or word size over a ready/valid handshake and drives the memory's word address, write data and write enable. Sub-word stores are done by read-modify-write, and sub-word loads are lane-selected and sign- or zero-extended. Misaligned and illegal-size requests are reported as errors and never touch memory.

## Interface
- No parameters; memory geometry is fixed at 128 words × 32 bits (9-bit byte address).
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-low reset (rst = 0 resets on the next rising edge)
- req_valid  in  1  CPU request present
- req_ready  out  1  controller idle and accepting; a request is taken when req_valid && req_ready
- req_store  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend
- req_addr  in  9  byte address; word index is [8:2], lane is [1:0]
- req_wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0])
- resp_done  out  1  one-cycle completion pulse
- resp_err  out  1  valid with resp_done: misaligned or illegal size
- resp_rdata  out  32  extended load result, valid with resp_done, held until next completion
- mem_addr  out  7  word address to data memory
- mem_wdata  out  32  full-word write data to data memory
- mem_we  out  1  data memory write enable
- mem_rdata  in  32  data memory combinational read data for mem_addr

## Operation
- States: IDLE, READ, WRITE, DONE. req_ready = (state == IDLE).
- IDLE, on acceptance: latch store, size, unsigned flag, lane, word index and wdata.
  - Error when size = 11, or size = 01 with addr[0] = 1, or size = 10 with addr[1:0] ≠ 00. Go to DONE with err = 1; no memory access.
  - Word store: go to WRITE.
  - Load or sub-word store: go to READ.
- READ: mem_addr = latched index, mem_we = 0. Capture mem_rdata into the word buffer. Load goes to DONE; sub-word store goes to WRITE.
- WRITE: mem_we = 1, mem_addr = latched index. Go to DONE.
  - Word store: mem_wdata = wdata.
  - Byte store: buffer with lane byte (lane×8 +: 8) replaced by wdata[7:0].
  - Half store: buffer with [lane×8 +: 16] replaced by wdata[15:0].
- DONE: resp_done = 1 for exactly one cycle. resp_err reflects the latched error. Go to IDLE.
- Load formatting (little-endian):
  - Byte loads select buffer[lane×8 +: 8].
  - Half loads select [lane×8 +: 16].
  - The selection is sign- or zero-extended to 32 bits per the unsigned flag. Word loads return the buffer unchanged.
- Load result registered into resp_rdata on entry to DONE. Stores and errors leave resp_rdata unchanged.
- mem_addr is driven from the latched index in every state, so it holds its last value in IDLE. mem_wdata is 0 outside WRITE.
- req_unsigned is ignored for stores. req_wdata upper bits are ignored for sub-word stores.

## Timing
- Request accepted at edge 0 → resp_done high in cycle:
  - misaligned or illegal: 1
  - word store: 2
  - load: 2
  - sub-word store: 3
- No back-to-back overlap: the next request can be accepted in the cycle after DONE, since IDLE follows DONE.
- mem_we is high for exactly one cycle per store, and never for loads or errors.
- Reset values: state IDLE, req_ready = 1, resp_done = 0, resp_err = 0, resp_rdata = 0, mem_addr = 0, mem_wdata = 0, mem_we = 0, all latches 0.
- Reset mid-operation: the transaction is aborted with no resp_done. mem_we is combinationally forced to 0 whenever rst = 0, so a WRITE coinciding with reset performs no write.
- req_valid while not ready is ignored, with no queuing. The CPU must hold the request until it is accepted.
- Write-then-read of the same word in consecutive transactions returns the new data, because memory writes complete at the WRITE edge.

## Test plan
- Reset with rst = 0 for 2 cycles → req_ready = 1, mem_we = 0, resp_rdata = 0, resp_done = 0.
- Word store 0xDEADBEEF at addr 0x010, then word load from 0x010 → mem_we pulses once with mem_addr = 4. Load resp_rdata = 0xDEADBEEF, and resp_done comes 2 cycles after each acceptance.
- Byte store 0xA5 at addr 0x012 onto word 0x11223344 → one READ cycle, then a WRITE of 0x11A53344; resp_done comes 3 cycles after acceptance.
- With word 4 = 0x80F07F01, perform loads:
  - signed byte at lane 3 → 0xFFFFFF80
  - unsigned byte at lane 3 → 0x00000080
  - signed half at lane 2 → 0xFFFF80F0
  - unsigned half at lane 0 → 0x00007F01
- Misaligned half at 0x013, word at 0x012, and size = 11 → resp_err = 1 one cycle after acceptance. mem_we never asserts and memory is unchanged.
- Drop rst to 0 during the WRITE cycle of a byte store → mem_we = 0 that cycle, the target word is unchanged, no resp_done occurs, and the controller returns to IDLE with req_ready = 1.
